vga_mem_arbiter: RTL and testbench
==================================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 22, memory word-address width.
REQ-002 Parameter DATA_W, default 32, memory word width (4 packed 8-bit pixels).
REQ-003 Parameter CPU_MAX_WAIT, default 16, range 1..255, consecutive denied cycles before the CPU is forced a slot.
REQ-004 Clocking and reset SHALL be one clock `clk`, with reset `rst_n` asynchronous and active-low.
REQ-005 Ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  async active-low reset.
- vga_req  in  1  pixel fetcher requests a read this cycle.
- vga_addr  in  ADDR_W  fetcher word address.
- vga_valid  out  1  vga_rdata holds returned data this cycle.
- vga_rdata  out  DATA_W  fetcher read data.
- vga_stall  out  1  vga_req was present last cycle but not issued.
- cpu_req  in  1  CPU access request, held until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU request issued.
- cpu_done  out  1  one-cycle pulse: access complete, cpu_rdata valid on reads.
- cpu_rdata  out  DATA_W  CPU read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  sync RAM data, valid 1 cycle after mem_en.

Function
REQ-006 Arbitration SHALL occur at each rising edge; the winner's mem_en/mem_we/mem_addr/mem_wdata SHALL be registered and appear in the following cycle (issue cycle).
REQ-007 Default priority SHALL go to VGA: if vga_req is high, VGA wins unless the starvation override in REQ-010 is active.
REQ-008 The CPU SHALL win when cpu_req is high and vga_req is low, or when the override is active.
REQ-009 The wait counter (8 bits) SHALL increment each edge where cpu_req is high and the CPU loses, clear on CPU win or when cpu_req is low, and saturate at CPU_MAX_WAIT.
REQ-010 The override SHALL be active when wait counter == CPU_MAX_WAIT.
REQ-011 The FSM SHALL have three states: IDLE (no access issued), VGA_RD (VGA read issued), and CPU_ACC (CPU access issued). The state is recomputed every edge from the winner, or IDLE if there is no request; back-to-back issue every cycle is permitted.
REQ-012 In VGA_RD the block SHALL drive mem_we=0 and mem_addr=vga_addr sampled at arbitration.
REQ-013 In CPU_ACC the block SHALL drive mem_we=cpu_we and mem_addr/mem_wdata sampled from the CPU at arbitration.
REQ-014 In CPU_ACC, cpu_gnt SHALL be high for the issue cycle only; the CPU may change inputs or present a new request the next cycle.
REQ-015 Return-path tags SHALL be registered:
- vga_valid SHALL be high exactly one cycle after each VGA_RD cycle.
- cpu_done SHALL be high exactly one cycle after each CPU_ACC cycle, for both reads and writes.
REQ-016 vga_rdata SHALL capture mem_rdata when vga_valid and hold its last value otherwise; cpu_rdata SHALL behave the same with cpu_done on reads and is unchanged on writes.
REQ-017 vga_stall SHALL be high in the cycle after any edge where vga_req was high and the CPU won.
REQ-018 A cpu_req deasserted before grant SHALL be a withdrawal: no grant is issued and the counter clears.
REQ-019 A CPU read and a following CPU write to the same address SHALL complete in order; the arbiter never reorders issued accesses.
REQ-020 Address and data SHALL pass through unmodified, with no width arithmetic beyond ADDR_W/DATA_W.

Reset
REQ-021 While rst_n=0 the block SHALL hold:
- FSM=IDLE and wait counter=0.
- mem_en, mem_we, cpu_gnt, cpu_done, vga_valid and vga_stall = 0.
- mem_addr, mem_wdata, vga_rdata and cpu_rdata = 0.
REQ-022 Reset asserted mid-access SHALL abort the access: no cpu_done or vga_valid follows, and the first arbitration is the first edge with rst_n=1.

Verification
REQ-023 VGA only: vga_req=1 continuously with addresses 0,1,2 -> mem_en=1 every cycle, vga_valid every cycle with a 1-cycle lag, vga_rdata = RAM[0],RAM[1],RAM[2].
REQ-024 CPU only: write 0xDEADBEEF to addr 22501, then read it -> cpu_gnt pulses, cpu_done 1 cycle after each gnt, cpu_rdata=0xDEADBEEF.
REQ-025 Starvation: vga_req=1 continuously, cpu_req=1 with CPU_MAX_WAIT=16 -> CPU granted on the 17th edge; vga_stall=1 for exactly one cycle; counter returns to 0.
REQ-026 Simultaneous requests with the counter below the limit -> VGA wins and cpu_gnt stays 0 that cycle.
REQ-027 Withdrawal: cpu_req=1 for 3 cycles under VGA load, then 0 -> no cpu_gnt, counter=0.
REQ-028 Reset mid-access: rst_n=0 during a CPU_ACC cycle -> cpu_done never asserts, all outputs 0 within the reset cycle.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Single-port memory arbiter between a VGA pixel fetcher (default priority) and a CPU.
// After CPU_MAX_WAIT consecutive losses the CPU is forced a slot; one access issues per cycle.
module vga_mem_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 32,
  parameter int CPU_MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_stall,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VGA_RD  = 2'd1,
    CPU_ACC = 2'd2
  } state_t;

  localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

  state_t            state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              vga_stall_q, vga_stall_d;
  logic              vga_valid_q, vga_valid_d;
  logic              cpu_done_q, cpu_done_d;
  logic              cpu_rd_ret_q, cpu_rd_ret_d;
  logic [DATA_W-1:0] vga_hold_q, vga_hold_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  logic              override, cpu_win, vga_win;

  always_comb begin
    override = (wait_q == MAX_WAIT);
    cpu_win  = cpu_req && (!vga_req || override);
    vga_win  = vga_req && !cpu_win;

    state_d = IDLE;
    if (cpu_win) begin
      state_d = CPU_ACC;
    end else if (vga_win) begin
      state_d = VGA_RD;
    end

    mem_en_d    = cpu_win || vga_win;
    mem_we_d    = cpu_win && cpu_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (cpu_win) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
    end else if (vga_win) begin
      mem_addr_d = vga_addr;
    end

    cpu_gnt_d   = cpu_win;
    vga_stall_d = vga_req && cpu_win;

    // Counter clears on a CPU win or an idle/withdrawn CPU, otherwise counts losses.
    wait_d = 8'd0;
    if (cpu_req && !cpu_win) begin
      wait_d = override ? wait_q : wait_q + 8'd1;
    end

    // Return tags follow the state issued last cycle; the sync RAM answers now.
    vga_valid_d  = (state_q == VGA_RD);
    cpu_done_d   = (state_q == CPU_ACC);
    cpu_rd_ret_d = (state_q == CPU_ACC) && !mem_we_q;
    vga_hold_d   = vga_valid_q ? mem_rdata : vga_hold_q;
    cpu_hold_d   = cpu_rd_ret_q ? mem_rdata : cpu_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_q       <= 8'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      vga_stall_q  <= 1'b0;
      vga_valid_q  <= 1'b0;
      cpu_done_q   <= 1'b0;
      cpu_rd_ret_q <= 1'b0;
      vga_hold_q   <= '0;
      cpu_hold_q   <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      vga_stall_q  <= vga_stall_d;
      vga_valid_q  <= vga_valid_d;
      cpu_done_q   <= cpu_done_d;
      cpu_rd_ret_q <= cpu_rd_ret_d;
      vga_hold_q   <= vga_hold_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_gnt   = cpu_gnt_q;
  assign vga_stall = vga_stall_q;
  assign vga_valid = vga_valid_q;
  assign cpu_done  = cpu_done_q;
  // Read data is presented in the same cycle as its tag and held afterwards.
  assign vga_rdata = vga_hold_d;
  assign cpu_rdata = cpu_hold_d;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: sync RAM model, transaction-level reference model,
// a vector table, directed corner sequences and a randomized run.
module tb_vga_mem_arbiter;
  localparam int AW   = 22;
  localparam int DW   = 32;
  localparam int MAXW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_valid;
  logic [DW-1:0] vga_rdata;
  logic          vga_stall;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_valid(vga_valid),
    .vga_rdata(vga_rdata), .vga_stall(vga_stall),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] ram_init(logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  // Environment: synchronous RAM, data valid the cycle after mem_en
  logic [DW-1:0] ram  [0:65535];
  logic [DW-1:0] mref [0:65535];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[15:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[15:0]];
    end
  end

  // Reference model: one issued operation per cycle, returns one cycle later
  typedef struct packed {
    logic          v;
    logic          cpu;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t           iss = '0;
  logic          e_stall = 1'b0;
  logic          e_vv = 1'b0;
  logic          e_cd = 1'b0;
  logic [DW-1:0] e_vrd = '0;
  logic [DW-1:0] e_crd = '0;
  int            waited = 0;

  always @(posedge clk) begin : model
    logic cw;
    if (!rst_n) begin
      iss     <= '0;
      e_stall <= 1'b0;
      e_vv    <= 1'b0;
      e_cd    <= 1'b0;
      e_vrd   <= '0;
      e_crd   <= '0;
      waited  <= 0;
    end else begin
      e_vv <= iss.v && !iss.cpu;
      e_cd <= iss.v && iss.cpu;
      if (iss.v && !iss.cpu) e_vrd <= mref[iss.addr[15:0]];
      if (iss.v && iss.cpu && iss.we) mref[iss.addr[15:0]] <= iss.wdata;
      if (iss.v && iss.cpu && !iss.we) e_crd <= mref[iss.addr[15:0]];
      cw = cpu_req && (!vga_req || waited >= MAXW);
      e_stall <= vga_req && cw;
      if (cw)           iss <= '{1'b1, 1'b1, cpu_we, cpu_addr, cpu_wdata};
      else if (vga_req) iss <= '{1'b1, 1'b0, 1'b0, vga_addr, '0};
      else              iss <= '0;
      if (cpu_req && !cw) waited <= (waited < MAXW) ? waited + 1 : waited;
      else                waited <= 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_mem_en", 64'(mem_en), 64'(0));
      chk("rst_mem_we", 64'(mem_we), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      chk("rst_cpu_gnt", 64'(cpu_gnt), 64'(0));
      chk("rst_cpu_done", 64'(cpu_done), 64'(0));
      chk("rst_vga_valid", 64'(vga_valid), 64'(0));
      chk("rst_vga_stall", 64'(vga_stall), 64'(0));
      chk("rst_vga_rdata", 64'(vga_rdata), 64'(0));
      chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    end else begin
      chk("m_mem_en", 64'(mem_en), 64'(iss.v));
      chk("m_mem_we", 64'(mem_we), 64'(iss.v && iss.cpu && iss.we));
      if (iss.v) chk("m_mem_addr", 64'(mem_addr), 64'(iss.addr));
      if (iss.v && iss.cpu && iss.we) chk("m_mem_wdata", 64'(mem_wdata), 64'(iss.wdata));
      chk("m_cpu_gnt", 64'(cpu_gnt), 64'(iss.v && iss.cpu));
      chk("m_vga_stall", 64'(vga_stall), 64'(e_stall));
      chk("m_vga_valid", 64'(vga_valid), 64'(e_vv));
      chk("m_cpu_done", 64'(cpu_done), 64'(e_cd));
      chk("m_vga_rdata", 64'(vga_rdata), 64'(e_vrd));
      chk("m_cpu_rdata", 64'(cpu_rdata), 64'(e_crd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic          creq;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwdata;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic          gnt;
    logic          stall;
    logic          vv;
    logic          cd;
    logic          ccrd;
    logic [DW-1:0] crd;
  } vec_t;

  function automatic vec_t mk(logic vreq, int vaddr, logic creq, logic cwe, int caddr,
                              logic [DW-1:0] cwdata, logic en, logic we, int addr,
                              logic gnt, logic vv, logic cd, logic ccrd, logic [DW-1:0] crd);
    vec_t r;
    r.vreq = vreq;  r.vaddr = AW'(vaddr); r.creq = creq; r.cwe = cwe;
    r.caddr = AW'(caddr); r.cwdata = cwdata; r.en = en; r.we = we; r.addr = AW'(addr);
    r.gnt = gnt; r.stall = 1'b0; r.vv = vv; r.cd = cd; r.ccrd = ccrd; r.crd = crd;
    return r;
  endfunction

  vec_t tbl [13];
  int   n_edges;
  int   n_stall;
  int   n_grants;
  logic withdrew;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]  <= ram_init(AW'(i));
      mref[i] <= ram_init(AW'(i));
    end

    tbl[0]  = mk(1'b0, 0,     1'b0, 1'b0, 0,     32'h0,         1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b1, 'h10,  1'b0, 1'b0, 0,     32'h0,         1'b1, 1'b0, 'h10,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tbl[2]  = mk(1'b1, 'h11,  1'b1, 1'b1, 'h200, 32'hAAAA_5555, 1'b1, 1'b0, 'h11,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[3]  = mk(1'b0, 0,     1'b1, 1'b1, 'h200, 32'hAAAA_5555, 1'b1, 1'b1, 'h200, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[4]  = mk(1'b0, 0,     1'b0, 1'b0, 0,     32'h0,         1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 0,     1'b1, 1'b0, 'h200, 32'h0,         1'b1, 1'b0, 'h200, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 0,     1'b0, 1'b0, 0,     32'h0,         1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA_5555);
    tbl[7]  = mk(1'b1, 'h20,  1'b1, 1'b0, 'h30,  32'h0,         1'b1, 1'b0, 'h20,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 0,     1'b1, 1'b0, 'h30,  32'h0,         1'b1, 1'b0, 'h30,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[9]  = mk(1'b1, 'h21,  1'b0, 1'b0, 0,     32'h0,         1'b1, 1'b0, 'h21,  1'b0, 1'b0, 1'b1, 1'b1, ram_init(AW'('h30)));
    tbl[10] = mk(1'b1, 'h22,  1'b1, 1'b1, 'h40,  32'h1234_5678, 1'b1, 1'b0, 'h22,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[11] = mk(1'b0, 0,     1'b0, 1'b0, 0,     32'h0,         1'b0, 1'b0, 0,     1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[12] = mk(1'b0, 0,     1'b0, 1'b0, 0,     32'h0,         1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset state
    repeat (3) tick();
    chk("reset_mem_en", 64'(mem_en), 64'(0));
    chk("reset_cpu_gnt", 64'(cpu_gnt), 64'(0));
    chk("reset_vga_valid", 64'(vga_valid), 64'(0));
    $display("reset held: mem_en=%0d cpu_gnt=%0d vga_valid=%0d", mem_en, cpu_gnt, vga_valid);
    rst_n = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 13; i++) begin
      vga_req = tbl[i].vreq;  vga_addr = tbl[i].vaddr;
      cpu_req = tbl[i].creq;  cpu_we = tbl[i].cwe;
      cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwdata;
      tick();
      chk("tbl_mem_en", 64'(mem_en), 64'(tbl[i].en));
      chk("tbl_mem_we", 64'(mem_we), 64'(tbl[i].we));
      if (tbl[i].en) chk("tbl_mem_addr", 64'(mem_addr), 64'(tbl[i].addr));
      chk("tbl_cpu_gnt", 64'(cpu_gnt), 64'(tbl[i].gnt));
      chk("tbl_vga_stall", 64'(vga_stall), 64'(tbl[i].stall));
      chk("tbl_vga_valid", 64'(vga_valid), 64'(tbl[i].vv));
      chk("tbl_cpu_done", 64'(cpu_done), 64'(tbl[i].cd));
      if (tbl[i].ccrd) chk("tbl_cpu_rdata", 64'(cpu_rdata), 64'(tbl[i].crd));
      $display("vec %0d: en=%0d we=%0d addr=%0h gnt=%0d vv=%0d cd=%0d", i,
               mem_en, mem_we, mem_addr, cpu_gnt, vga_valid, cpu_done);
    end

    // VGA streaming, addresses 0,1,2
    cpu_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vga_req  = (k < 3);
      vga_addr = AW'(k);
      tick();
      chk("vga_stream_en", 64'(mem_en), 64'(k < 3));
      if (k < 3) chk("vga_stream_addr", 64'(mem_addr), 64'(k));
      chk("vga_stream_valid", 64'(vga_valid), 64'(k >= 1 && k <= 3));
      if (k >= 1) chk("vga_stream_rdata", 64'(vga_rdata), 64'(ram_init(AW'((k <= 3) ? k - 1 : 2))));
      $display("vga stream %0d: en=%0d valid=%0d rdata=%0h", k, mem_en, vga_valid, vga_rdata);
    end

    // CPU write then read of 22501
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(22501); cpu_wdata = 32'hDEAD_BEEF;
    tick();
    chk("cpu_wr_gnt", 64'(cpu_gnt), 64'(1));
    chk("cpu_wr_mem_we", 64'(mem_we), 64'(1));
    chk("cpu_wr_mem_addr", 64'(mem_addr), 64'(22501));
    chk("cpu_wr_mem_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
    cpu_req = 1'b0;
    tick();
    chk("cpu_wr_gnt_pulse", 64'(cpu_gnt), 64'(0));
    chk("cpu_wr_done", 64'(cpu_done), 64'(1));
    $display("cpu write 22501 <= deadbeef done=%0d", cpu_done);
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    chk("cpu_rd_gnt", 64'(cpu_gnt), 64'(1));
    chk("cpu_rd_mem_we", 64'(mem_we), 64'(0));
    cpu_req = 1'b0;
    tick();
    chk("cpu_rd_done", 64'(cpu_done), 64'(1));
    chk("cpu_rd_data", 64'(cpu_rdata), 64'(32'hDEAD_BEEF));
    $display("cpu read 22501 -> %0h done=%0d", cpu_rdata, cpu_done);
    tick();
    chk("cpu_rd_done_pulse", 64'(cpu_done), 64'(0));
    chk("cpu_rd_data_hold", 64'(cpu_rdata), 64'(32'hDEAD_BEEF));

    // Starvation: forced slot on the 17th edge, twice back to back
    n_stall = 0;
    vga_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(5);
    n_edges = 0;
    for (int e = 0; e < 40; e++) begin
      vga_addr = AW'(e);
      tick();
      n_edges++;
      if (vga_stall) n_stall++;
      if (e < 16) chk("starve_no_gnt", 64'(cpu_gnt), 64'(0));
      if (cpu_gnt) break;
    end
    chk("starve_gnt_edge", 64'(n_edges), 64'(17));
    chk("starve_stall_at_gnt", 64'(vga_stall), 64'(1));
    $display("starvation: cpu granted after %0d edges, stall=%0d", n_edges, vga_stall);
    cpu_addr = AW'(6);
    n_edges = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      n_edges++;
      if (vga_stall) n_stall++;
      if (e == 0) chk("starve_stall_one_cycle", 64'(vga_stall), 64'(0));
      if (cpu_gnt) break;
    end
    chk("starve_regrant_edge", 64'(n_edges), 64'(17));
    chk("starve_stall_cycles", 64'(n_stall), 64'(2));
    $display("starvation: re-request granted after %0d edges, stall cycles=%0d", n_edges, n_stall);
    cpu_req = 1'b0;
    tick();
    chk("starve_after_stall", 64'(vga_stall), 64'(0));

    // Withdrawal under VGA load
    cpu_req = 1'b1; cpu_addr = AW'(7);
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("withdraw_no_gnt", 64'(cpu_gnt), 64'(0));
    end
    cpu_req = 1'b0;
    tick();
    chk("withdraw_no_gnt_after", 64'(cpu_gnt), 64'(0));
    cpu_req = 1'b1;
    n_edges = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      n_edges++;
      if (cpu_gnt) break;
    end
    chk("withdraw_counter_cleared", 64'(n_edges), 64'(17));
    $display("withdrawal: fresh request granted after %0d edges", n_edges);
    cpu_req = 1'b0; vga_req = 1'b0;
    tick();
    tick();

    // Reset during a CPU access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(22501);
    tick();
    chk("rstmid_gnt", 64'(cpu_gnt), 64'(1));
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_mem_en", 64'(mem_en), 64'(0));
    chk("rstmid_cpu_gnt", 64'(cpu_gnt), 64'(0));
    chk("rstmid_mem_addr", 64'(mem_addr), 64'(0));
    chk("rstmid_cpu_rdata", 64'(cpu_rdata), 64'(0));
    tick();
    chk("rstmid_no_done", 64'(cpu_done), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("rstmid_no_done_after", 64'(cpu_done), 64'(0));
    chk("rstmid_idle", 64'(mem_en), 64'(0));
    $display("reset mid-access: cpu_done=%0d mem_en=%0d", cpu_done, mem_en);

    // Randomized traffic checked by the reference model
    n_grants = 0;
    for (int c = 0; c < 600; c++) begin
      vga_req  = ($urandom_range(0, 99) < ((((c / 100) % 2) == 0) ? 95 : 40));
      vga_addr = AW'($urandom_range(0, 63));
      tick();
      withdrew = 1'b0;
      if (cpu_req && cpu_gnt) begin
        n_grants++;
        $display("rand cyc %0d: cpu grant we=%0d addr=%0h", c, cpu_we, cpu_addr);
        cpu_req = 1'b0;
      end else if (cpu_req && $urandom_range(0, 24) == 0) begin
        cpu_req  = 1'b0;
        withdrew = 1'b1;
      end
      if (!cpu_req && !withdrew && $urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = AW'($urandom_range(0, 63));
        cpu_wdata = $urandom;
      end
    end
    chk("rand_grants_seen", 64'(n_grants > 0), 64'(1));
    vga_req = 1'b0; cpu_req = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
